// File: rtl/mux_alloc.sv
// 2-input wormhole output allocator: packet lock HEAD..TAIL, round-robin at packet
// boundaries, optional per-VC downstream credit tracking (MUX_ALLOC_CREDIT_EN).
module mux_alloc #(
  parameter int VCHW  = 1,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ivalid_0,
  input  logic [1:0]      itype_0,
  input  logic [VCHW-1:0] ivch_0,
  input  logic            ivalid_1,
  input  logic [1:0]      itype_1,
  input  logic [VCHW-1:0] ivch_1,
  input  logic            icredit,
  input  logic [VCHW-1:0] icredit_vch,
  output logic [1:0]      sel,
  output logic            gnt_0,
  output logic            gnt_1,
  output logic            busy,
  output logic            err
);

  localparam int NVC = 2**VCHW;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b10;
  localparam logic [1:0] TYPE_DATA = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic            rr_q, rr_d;
  logic [VCHW-1:0] lock_vch_q, lock_vch_d;
  logic            err_q, err_d;

  logic            avail_0, avail_1, lock_avail;
  logic            cred_err;
  logic            elig_0, elig_1, pick_0, pick_1;
  logic [VCHW-1:0] xfer_vch;

`ifdef MUX_ALLOC_CREDIT_EN
  logic [CW-1:0] credit_q [NVC];
  logic [CW-1:0] credit_d [NVC];

  assign avail_0    = (credit_q[ivch_0] != '0);
  assign avail_1    = (credit_q[ivch_1] != '0);
  assign lock_avail = (credit_q[lock_vch_q] != '0);

  // A return and a transfer on the same VC cancel, so no overflow check then.
  always_comb begin
    cred_err = 1'b0;
    for (int unsigned v = 0; v < NVC; v++) begin
      credit_d[v] = credit_q[v];
      if (icredit && (icredit_vch == VCHW'(v)) &&
          !((gnt_0 || gnt_1) && (xfer_vch == VCHW'(v)))) begin
        if (credit_q[v] == DEPTH_C) cred_err = 1'b1;
        else                        credit_d[v] = credit_q[v] + CW'(1);
      end else if (!(icredit && (icredit_vch == VCHW'(v))) &&
                   (gnt_0 || gnt_1) && (xfer_vch == VCHW'(v))) begin
        credit_d[v] = credit_q[v] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned v = 0; v < NVC; v++) credit_q[v] <= DEPTH_C;
    end else begin
      for (int unsigned v = 0; v < NVC; v++) credit_q[v] <= credit_d[v];
    end
  end
`else
  logic unused_credit;

  assign avail_0       = 1'b1;
  assign avail_1       = 1'b1;
  assign lock_avail    = 1'b1;
  assign cred_err      = 1'b0;
  assign unused_credit = ^{icredit, icredit_vch, xfer_vch, DEPTH_C};
`endif

  assign elig_0 = ivalid_0 && (itype_0 == TYPE_HEAD) && avail_0;
  assign elig_1 = ivalid_1 && (itype_1 == TYPE_HEAD) && avail_1;
  assign pick_1 = elig_1 && (!elig_0 || rr_q);
  assign pick_0 = elig_0 && !pick_1;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    lock_vch_d = lock_vch_q;
    err_d      = err_q || cred_err;
    sel        = '0;
    gnt_0      = 1'b0;
    gnt_1      = 1'b0;
    xfer_vch   = lock_vch_q;
    case (state_q)
      IDLE: begin
        if (pick_1) begin
          sel        = 2'b10;
          gnt_1      = 1'b1;
          lock_vch_d = ivch_1;
          xfer_vch   = ivch_1;
          state_d    = LOCK1;
        end else if (pick_0) begin
          sel        = 2'b01;
          gnt_0      = 1'b1;
          lock_vch_d = ivch_0;
          xfer_vch   = ivch_0;
          state_d    = LOCK0;
        end
        // DATA/TAIL without a preceding HEAD is never granted
        if ((ivalid_0 && itype_0[1]) || (ivalid_1 && itype_1[1])) err_d = 1'b1;
      end
      LOCK0: begin
        sel   = 2'b01;
        gnt_0 = ivalid_0 && lock_avail;
        if (gnt_0) begin
          if (itype_0 == TYPE_TAIL) begin
            state_d = IDLE;
            rr_d    = 1'b1;
          end else if ((itype_0 == TYPE_HEAD) || (itype_0 == TYPE_NONE)) begin
            err_d = 1'b1;
          end
        end
      end
      LOCK1: begin
        sel   = 2'b10;
        gnt_1 = ivalid_1 && lock_avail;
        if (gnt_1) begin
          if (itype_1 == TYPE_TAIL) begin
            state_d = IDLE;
            rr_d    = 1'b0;
          end else if (itype_1 != TYPE_DATA) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      lock_vch_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lock_vch_q <= lock_vch_d;
      err_q      <= err_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign err  = err_q;

endmodule
